router_sync_n: RTL and testbench

Parametrised destination synchroniser for the router, sitting between the packet-control FSM and the NUM_PORTS output FIFOs. It latches the destination address from the header byte, steers the FSM's write strobe to exactly one FIFO, and reflects that FIFO's full flag back to the FSM. Per port, it drives the valid flag and runs a read-starvation watchdog that issues a soft-reset pulse to a FIFO whose valid data is not read within TIMEOUT cycles. It also flags illegal destination addresses instead of silently dropping them.

---
 rtl/router_pkg.sv | 9 +
 rtl/router_sync_wdog.sv | 52 +++++
 rtl/router_sync_n.sv | 90 +++++++++
 tb/tb_router_sync_n.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared constants and types for the router destination synchroniser.
package router_pkg;
  localparam int ROUTER_PORTS_DEFAULT       = 3;
  localparam int SOFT_RESET_TIMEOUT_DEFAULT = 30;
  localparam int STAT_W                     = 8;

  // Default-width per-port flag vector; the top builds its own from NUM_PORTS.
  typedef logic [ROUTER_PORTS_DEFAULT-1:0] port_vec_t;
endpackage

// File: rtl/router_sync_wdog.sv
// Per-port read-starvation watchdog: counts consecutive idle cycles (valid data
// not being read) and emits a one-cycle soft_reset every TIMEOUT idle cycles.
// Optional per-port pulse counter when ROUTER_SYNC_STATS_EN is defined.
module router_sync_wdog
  import router_pkg::*;
#(
  parameter int TIMEOUT = SOFT_RESET_TIMEOUT_DEFAULT
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              idle,
`ifdef ROUTER_SYNC_STATS_EN
  input  logic              stats_clr,
  output logic [STAT_W-1:0] sr_count,
`endif
  output logic              soft_reset
);
  localparam int            CW   = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CMAX = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;
  logic          fire;

  assign fire = idle && (cnt == CMAX);

  // Idle-run counter; wraps to zero on the cycle it fires the pulse.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      cnt        <= '0;
      soft_reset <= 1'b0;
    end else if (!idle) begin
      cnt        <= '0;
      soft_reset <= 1'b0;
    end else if (fire) begin
      cnt        <= '0;
      soft_reset <= 1'b1;
    end else begin
      cnt        <= cnt + 1'b1;
      soft_reset <= 1'b0;
    end
  end

`ifdef ROUTER_SYNC_STATS_EN
  // Saturating pulse counter; clear wins over a coincident pulse.
  always_ff @(posedge clock) begin
    if (!resetn || stats_clr)
      sr_count <= '0;
    else if (fire && (sr_count != '1))
      sr_count <= sr_count + 1'b1;
  end
`endif
endmodule

// File: rtl/router_sync_n.sv
// Router destination synchroniser: latches the header destination, steers the
// FSM write strobe to one FIFO, returns that FIFO's full flag, drives per-port
// valid and runs a starvation watchdog per port.
// Optional build macro: ROUTER_SYNC_STATS_EN adds stats_clr / sr_count.
module router_sync_n
  import router_pkg::*;
#(
  parameter int NUM_PORTS = ROUTER_PORTS_DEFAULT,
  parameter int ADDR_W    = $clog2(NUM_PORTS),
  parameter int TIMEOUT   = SOFT_RESET_TIMEOUT_DEFAULT
) (
  input  logic                        clock,
  input  logic                        resetn,
  input  logic                        detect_add,
  input  logic [ADDR_W-1:0]           data_in,
  input  logic                        write_enb_reg,
  input  logic [NUM_PORTS-1:0]        read_enb,
  input  logic [NUM_PORTS-1:0]        empty,
  input  logic [NUM_PORTS-1:0]        full,
`ifdef ROUTER_SYNC_STATS_EN
  input  logic                        stats_clr,
  output logic [NUM_PORTS*STAT_W-1:0] sr_count,
`endif
  output logic [NUM_PORTS-1:0]        vld_out,
  output logic [NUM_PORTS-1:0]        write_enb,
  output logic                        fifo_full,
  output logic                        addr_err,
  output logic [NUM_PORTS-1:0]        soft_reset
);
  typedef logic [NUM_PORTS-1:0] pvec_t;

  // One extra bit so NUM_PORTS itself is representable for the legality compare.
  localparam logic [ADDR_W:0] NP_W = (ADDR_W + 1)'(NUM_PORTS);

  if (NUM_PORTS < 2 || NUM_PORTS > 16) begin : g_bad_ports
    $error("router_sync_n: NUM_PORTS must be 2..16");
  end
  if (TIMEOUT < 2 || TIMEOUT > 1023) begin : g_bad_timeout
    $error("router_sync_n: TIMEOUT must be 2..1023");
  end
  if (ADDR_W < $clog2(NUM_PORTS)) begin : g_bad_addr
    $error("router_sync_n: ADDR_W too narrow for NUM_PORTS");
  end

  logic [ADDR_W-1:0] dest;
  logic              addr_vld;
  logic              addr_ok;
  pvec_t             idle;

  assign addr_ok = ({1'b0, data_in} < NP_W);

  // Destination latch, loaded on the header strobe and held otherwise.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      dest     <= '0;
      addr_vld <= 1'b0;
      addr_err <= 1'b0;
    end else if (detect_add) begin
      dest     <= data_in;
      addr_vld <= addr_ok;
      addr_err <= !addr_ok;
    end
  end

  // Write steering and full reflection use the previously latched destination.
  always_comb begin
    write_enb = '0;
    fifo_full = 1'b0;
    if (addr_vld) begin
      write_enb[dest] = write_enb_reg;
      fifo_full       = full[dest];
    end
  end

  assign vld_out = ~empty;
  assign idle    = vld_out & ~read_enb;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_wdog
    router_sync_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
      .clock      (clock),
      .resetn     (resetn),
      .idle       (idle[i]),
`ifdef ROUTER_SYNC_STATS_EN
      .stats_clr  (stats_clr),
      .sr_count   (sr_count[i*STAT_W +: STAT_W]),
`endif
      .soft_reset (soft_reset[i])
    );
  end
endmodule

// File: tb/tb_router_sync_n.sv
// Scoreboard bench for router_sync_n (NUM_PORTS=3, TIMEOUT=30): the driver
// pushes hand-computed expectations, a negedge monitor pops and compares.
module tb_router_sync_n;
  logic        clock = 1'b0;
  logic        resetn;
  logic        detect_add;
  logic [1:0]  data_in;
  logic        write_enb_reg;
  logic [2:0]  read_enb;
  logic [2:0]  empty;
  logic [2:0]  full;
  logic [2:0]  vld_out;
  logic [2:0]  write_enb;
  logic        fifo_full;
  logic        addr_err;
  logic [2:0]  soft_reset;
`ifdef ROUTER_SYNC_STATS_EN
  logic        stats_clr;
  logic [23:0] sr_count;
`endif

  typedef struct {
    string      name;
    logic [2:0] we;
    logic       ff;
    logic       err;
    logic [2:0] sr;
    logic [2:0] vld;
    bit         chk_cnt;
    logic [7:0] cnt0;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  router_sync_n #(.NUM_PORTS(3), .ADDR_W(2), .TIMEOUT(30)) dut (
    .clock         (clock),
    .resetn        (resetn),
    .detect_add    (detect_add),
    .data_in       (data_in),
    .write_enb_reg (write_enb_reg),
    .read_enb      (read_enb),
    .empty         (empty),
    .full          (full),
`ifdef ROUTER_SYNC_STATS_EN
    .stats_clr     (stats_clr),
    .sr_count      (sr_count),
`endif
    .vld_out       (vld_out),
    .write_enb     (write_enb),
    .fifo_full     (fifo_full),
    .addr_err      (addr_err),
    .soft_reset    (soft_reset)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation limit reached, queue=%0d", q.size());
    $fatal(1, "timeout");
  end

  // Monitor: one pending expectation is compared per falling edge.
  always @(negedge clock) begin
    if (q.size() > 0) begin
      exp_t e;
      bit   bad;
      e   = q.pop_front();
      bad = (write_enb !== e.we) || (fifo_full !== e.ff) || (addr_err !== e.err) ||
            (soft_reset !== e.sr) || (vld_out !== e.vld);
`ifdef ROUTER_SYNC_STATS_EN
      if (e.chk_cnt && (sr_count[7:0] !== e.cnt0)) bad = 1'b1;
`endif
      checks++;
      if (bad) begin
        errors++;
`ifdef ROUTER_SYNC_STATS_EN
        $display("FAIL %s: got we=%b ff=%b err=%b sr=%b vld=%b cnt0=%0d, want we=%b ff=%b err=%b sr=%b vld=%b cnt0=%0d",
                 e.name, write_enb, fifo_full, addr_err, soft_reset, vld_out, sr_count[7:0],
                 e.we, e.ff, e.err, e.sr, e.vld, e.cnt0);
`else
        $display("FAIL %s: got we=%b ff=%b err=%b sr=%b vld=%b, want we=%b ff=%b err=%b sr=%b vld=%b",
                 e.name, write_enb, fifo_full, addr_err, soft_reset, vld_out,
                 e.we, e.ff, e.err, e.sr, e.vld);
`endif
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_out(input string n, input logic [2:0] we, input logic ff,
                            input logic err, input logic [2:0] sr, input logic [2:0] vld);
    exp_t e;
    e.name = n; e.we = we; e.ff = ff; e.err = err; e.sr = sr; e.vld = vld;
    e.chk_cnt = 1'b0; e.cnt0 = 8'd0;
    q.push_back(e);
  endtask

  initial begin
    resetn = 1'b0; detect_add = 1'b0; data_in = 2'd0; write_enb_reg = 1'b0;
    read_enb = 3'b000; empty = 3'b111; full = 3'b000;
`ifdef ROUTER_SYNC_STATS_EN
    stats_clr = 1'b0;
`endif
    #1;
    step(); step();
    expect_out("reset_state", 3'b000, 1'b0, 1'b0, 3'b000, 3'b000);
    step();
    resetn = 1'b1;
    write_enb_reg = 1'b1;
    expect_out("no_addr_write", 3'b000, 1'b0, 1'b0, 3'b000, 3'b000);
    step();

    // Address decode: dest=2.
    detect_add = 1'b1; data_in = 2'd2; write_enb_reg = 1'b0;
    step();
    detect_add = 1'b0; write_enb_reg = 1'b1;
    expect_out("decode_dest2", 3'b100, 1'b0, 1'b0, 3'b000, 3'b000);
    step();
    full = 3'b100;
    expect_out("full_dest2", 3'b100, 1'b1, 1'b0, 3'b000, 3'b000);
    step();

    // Header and write together: old dest still steers this cycle.
    detect_add = 1'b1; data_in = 2'd0;
    expect_out("same_cycle_old", 3'b100, 1'b1, 1'b0, 3'b000, 3'b000);
    step();
    detect_add = 1'b0;
    expect_out("same_cycle_new", 3'b001, 1'b0, 1'b0, 3'b000, 3'b000);
    step();
    full = 3'b001;
    expect_out("write_to_full", 3'b001, 1'b1, 1'b0, 3'b000, 3'b000);
    step();
    full = 3'b000;

    // Illegal destination 3.
    detect_add = 1'b1; data_in = 2'd3; write_enb_reg = 1'b0;
    expect_out("illegal_pre", 3'b000, 1'b0, 1'b0, 3'b000, 3'b000);
    step();
    detect_add = 1'b0; write_enb_reg = 1'b1; full = 3'b111;
    expect_out("illegal_addr", 3'b000, 1'b0, 1'b1, 3'b000, 3'b000);
    step();
    detect_add = 1'b1; data_in = 2'd0;
    expect_out("illegal_hold", 3'b000, 1'b0, 1'b1, 3'b000, 3'b000);
    step();
    detect_add = 1'b0;
    expect_out("illegal_clear", 3'b001, 1'b1, 1'b0, 3'b000, 3'b000);
    step();
    full = 3'b000; write_enb_reg = 1'b0;

    // vld_out follows ~empty combinationally; read on empty port is harmless.
    empty = 3'b010; read_enb = 3'b010;
    expect_out("vld_follow", 3'b000, 1'b0, 1'b0, 3'b000, 3'b101);
    step();
    empty = 3'b111; read_enb = 3'b000;
    step();

    // Watchdog on port 1: pulses after idle edges 30 and 60, one cycle each.
    empty = 3'b101;
    for (int c = 0; c <= 61; c++) begin
      expect_out($sformatf("wdog_p1_c%0d", c), 3'b000, 1'b0, 1'b0,
                 (c == 30 || c == 60) ? 3'b010 : 3'b000, 3'b010);
      step();
    end
    empty = 3'b111;
    step();

    // Watchdog clear on port 0: 29 idle, one read, then 30 more idle.
    empty = 3'b110;
    for (int c = 0; c < 29; c++) begin
      expect_out($sformatf("wclr_pre_c%0d", c), 3'b000, 1'b0, 1'b0, 3'b000, 3'b001);
      step();
    end
    read_enb = 3'b001;
    expect_out("wclr_read", 3'b000, 1'b0, 1'b0, 3'b000, 3'b001);
    step();
    read_enb = 3'b000;
    for (int c = 0; c <= 30; c++) begin
      expect_out($sformatf("wclr_post_c%0d", c), 3'b000, 1'b0, 1'b0,
                 (c == 30) ? 3'b001 : 3'b000, 3'b001);
      step();
    end
    empty = 3'b111;
    step();

    // Reset mid-packet with port 1 partially starved.
    detect_add = 1'b1; data_in = 2'd1;
    step();
    detect_add = 1'b0; write_enb_reg = 1'b1; empty = 3'b101; full = 3'b010;
    for (int c = 0; c < 10; c++) begin
      expect_out("midpkt_we", 3'b010, 1'b1, 1'b0, 3'b000, 3'b010);
      step();
    end
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    for (int c = 0; c <= 30; c++) begin
      expect_out($sformatf("post_rst_c%0d", c), 3'b000, 1'b0, 1'b0,
                 (c == 30) ? 3'b010 : 3'b000, 3'b010);
      step();
    end
    write_enb_reg = 1'b0; full = 3'b000; empty = 3'b111;
    step();

`ifdef ROUTER_SYNC_STATS_EN
    // 300 pulses on port 0 saturate at 255; clear coinciding with a pulse wins.
    begin
      exp_t e;
      stats_clr = 1'b1;
      step();
      stats_clr = 1'b0;
      empty = 3'b110;
      repeat (300 * 30) step();
      e.name = "stats_sat"; e.we = 3'b000; e.ff = 1'b0; e.err = 1'b0;
      e.sr = 3'b001; e.vld = 3'b001; e.chk_cnt = 1'b1; e.cnt0 = 8'd255;
      q.push_back(e);
      repeat (29) step();
      stats_clr = 1'b1;
      step();
      stats_clr = 1'b0;
      e.name = "stats_clr_pulse"; e.cnt0 = 8'd0;
      q.push_back(e);
      step();
      empty = 3'b111;
      step();
    end
`endif

    begin
      int guard = 0;
      while (q.size() > 0 && guard < 10) begin
        step();
        guard++;
      end
      if (q.size() > 0) begin
        errors++;
        checks++;
        $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
